// File: rtl/down_counter_arbiter.sv
// Two-requester round-robin arbiter around a shared WIDTH-bit down counter.
// The winner's start value is loaded on the grant edge. The counter runs to zero, pulses done, then frees up.
module down_counter_arbiter #(
    parameter int unsigned WIDTH          = 3,
    parameter int unsigned FIRST_PRIORITY = 0
) (
    input  logic             CLK,
    input  logic             not_RST,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] load0,
    input  logic [WIDTH-1:0] load1,
    input  logic             pause,
    output logic             grant0,
    output logic             grant1,
    output logic             busy,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] Q
);

    typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

    localparam logic PtrReset = (FIRST_PRIORITY != 0);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             grant0_q, grant0_d;
    logic             grant1_q, grant1_d;
    logic             busy_q, busy_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    // ptr_q names the side that wins when both requesters are pending.
    logic             ptr_q, ptr_d;
    logic             pick0, pick1, owner_req;

    assign pick0     = req0 & (~req1 | ~ptr_q);
    assign pick1     = req1 & ~pick0;
    assign owner_req = grant1_q ? req1 : req0;

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        grant0_d = grant0_q;
        grant1_d = grant1_q;
        busy_d   = busy_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        ptr_d    = ptr_q;
        case (state_q)
            StIdle: begin
                if (pick0) begin
                    state_d  = StCount;
                    q_d      = load0;
                    grant0_d = 1'b1;
                    busy_d   = 1'b1;
                    ptr_d    = 1'b1;
                end else if (pick1) begin
                    state_d  = StCount;
                    q_d      = load1;
                    grant1_d = 1'b1;
                    busy_d   = 1'b1;
                    ptr_d    = 1'b0;
                end
            end
            StCount: begin
                if (!owner_req) begin
                    state_d  = StIdle;
                    q_d      = '0;
                    grant0_d = 1'b0;
                    grant1_d = 1'b0;
                    busy_d   = 1'b0;
                end else if (pause) begin
                    state_d = StCount;
                end else if (q_q != '0) begin
                    q_d = q_q - WIDTH'(1);
                end else begin
                    state_d = StDone;
                    done0_d = grant0_q;
                    done1_d = grant1_q;
                end
            end
            StDone: begin
                state_d  = StIdle;
                q_d      = '0;
                grant0_d = 1'b0;
                grant1_d = 1'b0;
                busy_d   = 1'b0;
            end
            default: begin
                state_d  = StIdle;
                q_d      = '0;
                grant0_d = 1'b0;
                grant1_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge not_RST) begin
        if (!not_RST) begin
            state_q  <= StIdle;
            q_q      <= '0;
            grant0_q <= 1'b0;
            grant1_q <= 1'b0;
            busy_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            ptr_q    <= PtrReset;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            grant0_q <= grant0_d;
            grant1_q <= grant1_d;
            busy_q   <= busy_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            ptr_q    <= ptr_d;
        end
    end

    assign grant0 = grant0_q;
    assign grant1 = grant1_q;
    assign busy   = busy_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign Q      = q_q;

endmodule

// File: tb/tb_down_counter_arbiter.sv
// Directed bench for down_counter_arbiter (WIDTH=3, FIRST_PRIORITY=0).
// Outputs are packed as {grant0, grant1, busy, done0, done1, Q}.
module tb_down_counter_arbiter;

    logic       CLK;
    logic       not_RST;
    logic       req0, req1, pause;
    logic [2:0] load0, load1;
    logic       grant0, grant1, busy, done0, done1;
    logic [2:0] Q;
    logic [7:0] obs;
    logic [7:0] exp_v;

    int n_cmp = 0;
    int n_err = 0;

    down_counter_arbiter #(
        .WIDTH          (3),
        .FIRST_PRIORITY (0)
    ) dut (
        .CLK     (CLK),
        .not_RST (not_RST),
        .req0    (req0),
        .req1    (req1),
        .load0   (load0),
        .load1   (load1),
        .pause   (pause),
        .grant0  (grant0),
        .grant1  (grant1),
        .busy    (busy),
        .done0   (done0),
        .done1   (done1),
        .Q       (Q)
    );

    assign obs = {grant0, grant1, busy, done0, done1, Q};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (not_RST === 1'b1) begin
            n_cmp++;
            if ((grant0 & grant1) || (done0 & done1) || (!busy && Q != 3'd0)) begin
                n_err++;
                $display("FAIL invariant: got %b, required one-hot grant/done and Q=0 when idle", obs);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_dut();
        req0    = 1'b0;
        req1    = 1'b0;
        pause   = 1'b0;
        not_RST = 1'b0;
        #12;
        @(negedge CLK);
        not_RST = 1'b1;
    endtask

    task automatic test_reset();
        not_RST = 1'b1;
        req0 = 1'b0; req1 = 1'b0; pause = 1'b0; load0 = 3'd0; load1 = 3'd0;
        #1 not_RST = 1'b0;
        #2;
        n_cmp++;
        if (obs !== 8'b0) begin
            n_err++;
            $display("FAIL reset_async: got %b, required %b", obs, 8'b0);
        end
        step();
        n_cmp++;
        if (obs !== 8'b0) begin
            n_err++;
            $display("FAIL reset_held: got %b, required %b", obs, 8'b0);
        end
        @(negedge CLK);
        not_RST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (obs !== 8'b0) begin
                n_err++;
                $display("FAIL idle_cycle%0d: got %b, required %b", i, obs, 8'b0);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        req0 = 1'b1; load0 = 3'd4;
        step();
        step();
        n_cmp++;
        if (obs !== {5'b10100, 3'd3}) begin
            n_err++;
            $display("FAIL mid_pre: got %b, required %b", obs, {5'b10100, 3'd3});
        end
        @(negedge CLK);
        #2 not_RST = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 8'b0) begin
            n_err++;
            $display("FAIL mid_reset: got %b, required %b", obs, 8'b0);
        end
        req0 = 1'b0;
        @(negedge CLK);
        not_RST = 1'b1;
    endtask

    task automatic test_single_job();
        reset_dut();
        req0 = 1'b1; load0 = 3'd5;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 1) load0 = 3'd2;
            if (e <= 6)      exp_v = {5'b10100, 3'(6 - e)};
            else if (e == 7) exp_v = {5'b10110, 3'd0};
            else             exp_v = 8'b0;
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL single_edge%0d: got %b, required %b", e, obs, exp_v);
            end
            if (e == 7) req0 = 1'b0;
        end
    endtask

    task automatic test_contention();
        reset_dut();
        req0 = 1'b1; req1 = 1'b1; load0 = 3'd2; load1 = 3'd3;
        for (int e = 1; e <= 11; e++) begin
            step();
            case (e)
                1, 2, 3:     exp_v = {5'b10100, 3'(3 - e)};
                4:           exp_v = {5'b10110, 3'd0};
                5:           exp_v = 8'b0;
                6, 7, 8, 9:  exp_v = {5'b01100, 3'(9 - e)};
                10:          exp_v = {5'b01101, 3'd0};
                default:     exp_v = 8'b0;
            endcase
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL contention_edge%0d: got %b, required %b", e, obs, exp_v);
            end
            if (e == 4)  req0 = 1'b0;
            if (e == 10) req1 = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        reset_dut();
        req0 = 1'b1; req1 = 1'b1; load0 = 3'd1; load1 = 3'd1;
        for (int e = 1; e <= 16; e++) begin
            int ph;
            int side;
            step();
            ph   = (e - 1) % 4;
            side = ((e - 1) / 4) % 2;
            case (ph)
                0:       exp_v = (side == 0) ? {5'b10100, 3'd1} : {5'b01100, 3'd1};
                1:       exp_v = (side == 0) ? {5'b10100, 3'd0} : {5'b01100, 3'd0};
                2:       exp_v = (side == 0) ? {5'b10110, 3'd0} : {5'b01101, 3'd0};
                default: exp_v = 8'b0;
            endcase
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL rr_edge%0d: got %b, required %b", e, obs, exp_v);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    task automatic test_boundaries();
        reset_dut();
        req0 = 1'b1; load0 = 3'd0;
        for (int e = 1; e <= 3; e++) begin
            step();
            case (e)
                1:       exp_v = {5'b10100, 3'd0};
                2:       exp_v = {5'b10110, 3'd0};
                default: exp_v = 8'b0;
            endcase
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL load0_edge%0d: got %b, required %b", e, obs, exp_v);
            end
            if (e == 2) req0 = 1'b0;
        end
        // pause is high on the grant edge; IDLE must ignore it
        req0 = 1'b1; load0 = 3'd7; pause = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            step();
            if (e == 1) pause = 1'b0;
            case (e)
                1, 2, 3, 4:       exp_v = {5'b10100, 3'(8 - e)};
                5, 6, 7:          exp_v = {5'b10100, 3'd4};
                8, 9, 10, 11:     exp_v = {5'b10100, 3'(11 - e)};
                12:               exp_v = {5'b10110, 3'd0};
                default:          exp_v = 8'b0;
            endcase
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL pause_edge%0d: got %b, required %b", e, obs, exp_v);
            end
            if (e == 4)  pause = 1'b1;
            if (e == 7)  pause = 1'b0;
            if (e == 12) req0 = 1'b0;
        end
    endtask

    task automatic test_abort();
        reset_dut();
        req1 = 1'b1; load1 = 3'd5;
        for (int e = 1; e <= 7; e++) begin
            step();
            case (e)
                1, 2, 3, 4: exp_v = {5'b01100, 3'(6 - e)};
                5:          exp_v = 8'b0;
                6:          exp_v = {5'b10100, 3'd6};
                default:    exp_v = 8'b0;
            endcase
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL abort_edge%0d: got %b, required %b", e, obs, exp_v);
            end
            if (e == 4) begin
                req1 = 1'b0; req0 = 1'b1; load0 = 3'd6;
            end
            if (e == 6) req0 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_single_job();
        test_contention();
        test_round_robin();
        test_boundaries();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
